// File: rtl/aes_definitions_pkg.sv
// AES shared types, round-count constants and GF(2^8)/row-shift helpers.
// Used by shift_mix_stage and mix_column.
package AESDefinitions;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam int AES_NUM_ROUNDS_128 = 10;
  localparam int AES_NUM_ROUNDS_192 = 12;
  localparam int AES_NUM_ROUNDS_256 = 14;

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // s[r][c] lives at bits [127-8*(4c+r) -: 8]
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/shift_mix_stage_mix_column.sv
// One-column MixColumns over GF(2^8); row 0 in the top byte.
// SHIFT_MIX_INVERSE_EN adds inv_i selecting InvMixColumns.
module mix_column
  import AESDefinitions::*;
(
  input  logic [31:0] col_i,
`ifdef SHIFT_MIX_INVERSE_EN
  input  logic        inv_i,
`endif
  output logic [31:0] col_o
);

  byte_t a0, a1, a2, a3;
  byte_t f0, f1, f2, f3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign f0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
  assign f1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
  assign f2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
  assign f3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);

`ifdef SHIFT_MIX_INVERSE_EN
  byte_t i0, i1, i2, i3;

  assign i0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
            ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
  assign i1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
            ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
  assign i2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
            ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
  assign i3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
            ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

  assign col_o = inv_i ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
`else
  assign col_o = {f0, f1, f2, f3};
`endif

endmodule

// File: rtl/shift_mix_stage.sv
// AES ShiftRows+MixColumns round stage with a 2-entry skid buffer.
// SHIFT_MIX_INVERSE_EN adds in_decrypt/out_decrypt for the inverse path.
module shift_mix_stage
  import AESDefinitions::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS_128,
  parameter int TAG_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [TAG_W-1:0] in_round,
`ifdef SHIFT_MIX_INVERSE_EN
  input  logic             in_decrypt,
  output logic             out_decrypt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_round
);

  localparam logic [TAG_W-1:0] FINAL_RND = TAG_W'(NUM_ROUNDS);

  logic   dec;
  state_t sr_s;
  state_t mix_in;
  state_t mix_out;
  state_t mixed;
  state_t res;

`ifdef SHIFT_MIX_INVERSE_EN
  assign dec = in_decrypt;
`else
  assign dec = 1'b0;
`endif

  // Inverse column mix runs before the inverse row shift so that
  // a decrypt beat exactly undoes an encrypt beat.
  always_comb begin
    sr_s   = dec ? inv_shift_rows(in_state) : shift_rows(in_state);
    mix_in = dec ? in_state : sr_s;
    mixed  = dec ? inv_shift_rows(mix_out) : mix_out;
    res    = (in_round == FINAL_RND) ? sr_s : mixed;
  end

  for (genvar g = 0; g < 4; g++) begin : g_col
    mix_column u_mix (
      .col_i (mix_in[127-32*g -: 32]),
`ifdef SHIFT_MIX_INVERSE_EN
      .inv_i (dec),
`endif
      .col_o (mix_out[127-32*g -: 32])
    );
  end

  logic             out_vld_q, out_vld_d;
  state_t           out_st_q, out_st_d;
  logic [TAG_W-1:0] out_rd_q, out_rd_d;
  logic             skid_vld_q, skid_vld_d;
  state_t           skid_st_q, skid_st_d;
  logic [TAG_W-1:0] skid_rd_q, skid_rd_d;
`ifdef SHIFT_MIX_INVERSE_EN
  logic             out_dec_q, out_dec_d;
  logic             skid_dec_q, skid_dec_d;
`endif

  logic push;
  logic pop;

  assign push = in_valid && !skid_vld_q;
  assign pop  = out_vld_q && out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_st_d   = out_st_q;
    out_rd_d   = out_rd_q;
    skid_vld_d = skid_vld_q;
    skid_st_d  = skid_st_q;
    skid_rd_d  = skid_rd_q;
`ifdef SHIFT_MIX_INVERSE_EN
    out_dec_d  = out_dec_q;
    skid_dec_d = skid_dec_q;
`endif
    if (skid_vld_q) begin
      if (pop) begin
        out_st_d   = skid_st_q;
        out_rd_d   = skid_rd_q;
        skid_vld_d = 1'b0;
`ifdef SHIFT_MIX_INVERSE_EN
        out_dec_d  = skid_dec_q;
`endif
      end
    end else if (push) begin
      if (!out_vld_q || pop) begin
        out_vld_d = 1'b1;
        out_st_d  = res;
        out_rd_d  = in_round;
`ifdef SHIFT_MIX_INVERSE_EN
        out_dec_d = dec;
`endif
      end else begin
        skid_vld_d = 1'b1;
        skid_st_d  = res;
        skid_rd_d  = in_round;
`ifdef SHIFT_MIX_INVERSE_EN
        skid_dec_d = dec;
`endif
      end
    end else if (pop) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_st_q   <= '0;
      out_rd_q   <= '0;
      skid_vld_q <= 1'b0;
      skid_st_q  <= '0;
      skid_rd_q  <= '0;
`ifdef SHIFT_MIX_INVERSE_EN
      out_dec_q  <= 1'b0;
      skid_dec_q <= 1'b0;
`endif
    end else begin
      out_vld_q  <= out_vld_d;
      out_st_q   <= out_st_d;
      out_rd_q   <= out_rd_d;
      skid_vld_q <= skid_vld_d;
      skid_st_q  <= skid_st_d;
      skid_rd_q  <= skid_rd_d;
`ifdef SHIFT_MIX_INVERSE_EN
      out_dec_q  <= out_dec_d;
      skid_dec_q <= skid_dec_d;
`endif
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign out_state = out_st_q;
  assign out_round = out_rd_q;
`ifdef SHIFT_MIX_INVERSE_EN
  assign out_decrypt = out_dec_q;
`endif

endmodule

// File: tb/tb_shift_mix_stage.sv
// Directed self-checking bench for shift_mix_stage.
// Inverse-path scenario included when SHIFT_MIX_INVERSE_EN is defined.
module tb_shift_mix_stage;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
`ifdef SHIFT_MIX_INVERSE_EN
  logic         in_decrypt;
  logic         out_decrypt;
`endif

  int checks;
  int errors;

  shift_mix_stage #(.NUM_ROUNDS(10), .TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_round  (in_round),
`ifdef SHIFT_MIX_INVERSE_EN
    .in_decrypt  (in_decrypt),
    .out_decrypt (out_decrypt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Presents one beat with out_ready high and samples the output one cycle later.
  task automatic beat(input logic [127:0] s, input logic [3:0] r,
                      input logic d, output logic [127:0] os,
                      output logic [3:0] orr, output logic ov);
    @(negedge clock);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = s;
    in_round  = r;
`ifdef SHIFT_MIX_INVERSE_EN
    in_decrypt = d;
`else
    if (d) in_valid = 1'b1;
`endif
    @(negedge clock);
    in_valid = 1'b0;
    ov  = out_valid;
    os  = out_state;
    orr = out_round;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_round  = '0;
    out_ready = 1'b1;
`ifdef SHIFT_MIX_INVERSE_EN
    in_decrypt = 1'b0;
`endif
    repeat (2) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_state !== 128'h0 || out_round !== 4'h0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b state=%h round=%h want 0 1 0 0",
               out_valid, in_ready, out_state, out_round);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_shift_rows();
    logic [127:0] os;
    logic [3:0]   orr;
    logic         ov;
    beat(128'h000102030405060708090a0b0c0d0e0f, 4'd10, 1'b0, os, orr, ov);
    checks++;
    if (ov !== 1'b1 || os !== 128'h00050a0f04090e03080d02070c01060b) begin
      errors++;
      $display("FAIL shift_rows: valid=%b state=%h want 1 00050a0f04090e03080d02070c01060b",
               ov, os);
    end
    checks++;
    if (orr !== 4'd10) begin
      errors++;
      $display("FAIL shift_rows_round: got %0d want 10", orr);
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL shift_rows_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_fips_round();
    logic [127:0] os;
    logic [3:0]   orr;
    logic         ov;
    logic [3:0]   rnds [3];
    rnds[0] = 4'd1;
    rnds[1] = 4'd0;
    rnds[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      beat(128'hd42711aee0bf98f1b8b45de51e415230, rnds[i], 1'b0, os, orr, ov);
      checks++;
      if (ov !== 1'b1 || os !== 128'h046681e5e0cb199a48f8d37a2806264c ||
          orr !== rnds[i]) begin
        errors++;
        $display("FAIL fips_round%0d: valid=%b state=%h round=%0d want 046681e5e0cb199a48f8d37a2806264c",
                 rnds[i], ov, os, orr);
      end
    end
    beat(128'hd42711aee0bf98f1b8b45de51e415230, 4'd10, 1'b0, os, orr, ov);
    checks++;
    if (os !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      errors++;
      $display("FAIL fips_final: got %h want d4bf5d30e0b452aeb84111f11e2798e5", os);
    end
  endtask

  task automatic test_columns();
    logic [127:0] os;
    logic [3:0]   orr;
    logic         ov;
    beat({4{32'hdb135345}}, 4'd1, 1'b0, os, orr, ov);
    checks++;
    if (os !== {4{32'h8e4da1bc}}) begin
      errors++;
      $display("FAIL column_db135345: got %h want 8e4da1bc x4", os);
    end
    beat({16{8'h01}}, 4'd1, 1'b0, os, orr, ov);
    checks++;
    if (os !== {16{8'h01}}) begin
      errors++;
      $display("FAIL column_01: got %h want 01 x16", os);
    end
  endtask

  // Equal-column states with the final round tag pass through unchanged.
  task automatic test_backpressure();
    logic [127:0] vec [4];
    int sent;
    int got;
    sent = 0;
    got  = 0;
    for (int i = 0; i < 4; i++) vec[i] = {4{32'ha0b1c2d3 + 32'(i)}};
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      in_state  = vec[sent < 4 ? sent : 3];
      in_round  = 4'd10;
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_state !== vec[0]) begin
          errors++;
          $display("FAIL bp_hold: ready=%b valid=%b state=%h want 0 1 %h",
                   in_ready, out_valid, out_state, vec[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (got >= 4 || out_state !== vec[got < 4 ? got : 3] || out_round !== 4'd10) begin
          errors++;
          $display("FAIL bp_order%0d: state=%h round=%0d want %h 10",
                   got, out_state, out_round, vec[got < 4 ? got : 3]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4 || sent !== 4) begin
      errors++;
      $display("FAIL bp_count: got=%0d sent=%0d want 4 4", got, sent);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = {4{32'h12345678}};
    in_round  = 4'd10;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_before_reset: ready=%b valid=%b want 0 1", in_ready, out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b state=%h want 0 1 0",
               out_valid, in_ready, out_state);
    end
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out_valid=%b want 0", out_valid);
    end
  endtask

`ifdef SHIFT_MIX_INVERSE_EN
  task automatic test_inverse();
    logic [127:0] os;
    logic [127:0] x;
    logic [127:0] y;
    logic [3:0]   orr;
    logic         ov;
    beat(128'h046681e5e0cb199a48f8d37a2806264c, 4'd1, 1'b1, os, orr, ov);
    checks++;
    if (os !== 128'hd42711aee0bf98f1b8b45de51e415230 || out_decrypt !== 1'b1) begin
      errors++;
      $display("FAIL inverse_fips: got %h dec=%b want d42711aee0bf98f1b8b45de51e415230 1",
               os, out_decrypt);
    end
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      beat(x, 4'(i + 2), 1'b0, y, orr, ov);
      beat(y, 4'(i + 2), 1'b1, os, orr, ov);
      checks++;
      if (os !== x) begin
        errors++;
        $display("FAIL roundtrip%0d: got %h want %h", i, os, x);
      end
    end
    in_decrypt = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_shift_rows();
    test_fips_round();
    test_columns();
    test_backpressure();
    test_reset_mid();
`ifdef SHIFT_MIX_INVERSE_EN
    test_inverse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
